// File: rtl/run_mode_controller_pkg.sv
// rtl/run_mode_controller_pkg.sv - shared JPEG-LS run-mode widths, J table and state encoding
package run_mode_controller_pkg;

    localparam int J_LENGTH        = 4;
    localparam int RUNCOUNT_LENGTH = 16;
    localparam int RUNINDEX_LENGTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RI_SEG  = 2'd2,
        ST_RI_BUSY = 2'd3
    } run_state_e;

    localparam logic [J_LENGTH-1:0] J_TABLE [0:31] = '{
        4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd1,  4'd1,
        4'd2,  4'd2,  4'd2,  4'd2,  4'd3,  4'd3,  4'd3,  4'd3,
        4'd4,  4'd4,  4'd5,  4'd5,  4'd6,  4'd6,  4'd7,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

endpackage

// File: rtl/run_index_table.sv
// rtl/run_index_table.sv - combinational RUNindex-to-J lookup, shared with the decoder
module run_index_table
    import run_mode_controller_pkg::*;
(
    input  logic [RUNINDEX_LENGTH-1:0] run_index_i,
    output logic [J_LENGTH-1:0]        j_o
);

    assign j_o = J_TABLE[run_index_i];

endmodule

// File: rtl/run_mode_controller.sv
// rtl/run_mode_controller.sv - JPEG-LS run-mode controller; RUN_STATS_EN adds run_pixel_count
module run_mode_controller
    import run_mode_controller_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       px_valid,
    output logic                       px_ready,
    input  logic                       run_mode_req,
    input  logic                       px_match,
    input  logic                       px_eol,
    output logic                       seg_valid,
    input  logic                       seg_ready,
    output logic [15:0]                seg_bits,
    output logic [4:0]                 seg_length,
    output logic                       ri_start,
    input  logic                       ri_done,
    output logic [J_LENGTH-1:0]        J_Comp,
    output logic [RUNINDEX_LENGTH-1:0] run_index,
`ifdef RUN_STATS_EN
    output logic [31:0]                run_pixel_count,
`endif
    output logic                       busy
);

    run_state_e                 state_q, state_d;
    logic [RUNCOUNT_LENGTH-1:0] cnt_q, cnt_d;
    logic [RUNINDEX_LENGTH-1:0] idx_q, idx_d;
    logic                       seg_valid_q, seg_valid_d;
    logic [15:0]                seg_bits_q, seg_bits_d;
    logic [4:0]                 seg_len_q, seg_len_d;
    logic                       ri_start_q, ri_start_d;
    logic [J_LENGTH-1:0]        j_comp_q, j_comp_d;

    logic [J_LENGTH-1:0]        j;
    logic [RUNCOUNT_LENGTH-1:0] cnt_inc;
    logic [RUNCOUNT_LENGTH-1:0] j_mask;
    logic [15:0]                ri_bits;
    logic                       full_run;
    logic                       seg_free;
    logic                       px_fire;
    logic                       run_px;

    run_index_table u_run_index_table (
        .run_index_i (idx_q),
        .j_o         (j)
    );

    assign cnt_inc  = cnt_q + 16'd1;
    assign full_run = (cnt_inc == (16'd1 << j));
    assign j_mask   = (16'd1 << j) - 16'd1;
    // '0' marker at bit 15, then the J low bits of RUNcnt directly below it
    assign ri_bits  = (cnt_q & j_mask) << (4'd15 - j);
    assign seg_free = !seg_valid_q || seg_ready;
    assign px_ready = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && seg_free;
    assign px_fire  = px_valid && px_ready;
    assign run_px   = px_fire && ((state_q == ST_RUN) || run_mode_req);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        seg_valid_d = seg_valid_q && !seg_ready;
        seg_bits_d  = seg_bits_q;
        seg_len_d   = seg_len_q;
        ri_start_d  = 1'b0;
        j_comp_d    = j_comp_q;

        if (run_px) begin
            if (px_match) begin
                if (full_run) begin
                    seg_valid_d = 1'b1;
                    seg_bits_d  = 16'h8000;
                    seg_len_d   = 5'd1;
                    cnt_d       = '0;
                    idx_d       = (idx_q == 5'd31) ? idx_q : idx_q + 5'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
                if (px_eol) begin
                    // partial run at end of line is closed with a single '1'
                    if (!full_run && (cnt_inc != '0)) begin
                        seg_valid_d = 1'b1;
                        seg_bits_d  = 16'h8000;
                        seg_len_d   = 5'd1;
                        cnt_d       = '0;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                seg_valid_d = 1'b1;
                seg_bits_d  = ri_bits;
                seg_len_d   = {1'b0, j} + 5'd1;
                state_d     = ST_RI_SEG;
            end
        end

        case (state_q)
            ST_RI_SEG: begin
                if (seg_valid_q && seg_ready) begin
                    ri_start_d = 1'b1;
                    j_comp_d   = j;
                    state_d    = ST_RI_BUSY;
                end
            end
            ST_RI_BUSY: begin
                if (ri_done) begin
                    idx_d   = (idx_q == '0) ? idx_q : idx_q - 5'd1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            seg_valid_q <= 1'b0;
            seg_bits_q  <= '0;
            seg_len_q   <= '0;
            ri_start_q  <= 1'b0;
            j_comp_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            seg_valid_q <= seg_valid_d;
            seg_bits_q  <= seg_bits_d;
            seg_len_q   <= seg_len_d;
            ri_start_q  <= ri_start_d;
            j_comp_q    <= j_comp_d;
        end
    end

`ifdef RUN_STATS_EN
    logic [31:0] stats_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stats_q <= '0;
        end else if (run_px && px_match) begin
            stats_q <= stats_q + 32'd1;
        end
    end

    assign run_pixel_count = stats_q;
`endif

    assign seg_valid  = seg_valid_q;
    assign seg_bits   = seg_bits_q;
    assign seg_length = seg_len_q;
    assign ri_start   = ri_start_q;
    assign J_Comp     = j_comp_q;
    assign run_index  = idx_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_run_mode_controller.sv
// tb/tb_run_mode_controller.sv - scoreboard bench for run_mode_controller
module tb_run_mode_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        px_valid = 1'b0;
    logic        run_mode_req = 1'b0;
    logic        px_match = 1'b0;
    logic        px_eol = 1'b0;
    logic        seg_ready = 1'b1;
    logic        ri_done = 1'b0;
    logic        px_ready;
    logic        seg_valid;
    logic [15:0] seg_bits;
    logic [4:0]  seg_length;
    logic        ri_start;
    logic [3:0]  J_Comp;
    logic [4:0]  run_index;
    logic        busy;
`ifdef RUN_STATS_EN
    logic [31:0] run_pixel_count;
`endif

    run_mode_controller dut (
        .clk          (clk),
        .reset        (reset),
        .px_valid     (px_valid),
        .px_ready     (px_ready),
        .run_mode_req (run_mode_req),
        .px_match     (px_match),
        .px_eol       (px_eol),
        .seg_valid    (seg_valid),
        .seg_ready    (seg_ready),
        .seg_bits     (seg_bits),
        .seg_length   (seg_length),
        .ri_start     (ri_start),
        .ri_done      (ri_done),
        .J_Comp       (J_Comp),
        .run_index    (run_index),
`ifdef RUN_STATS_EN
        .run_pixel_count (run_pixel_count),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        logic [4:0]  len;
    } seg_t;

    int   tests_run = 0;
    int   tests_failed = 0;
    seg_t exp_q[$];
    seg_t mon_e;
    int   jt[32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};
    int          m_idx = 0;
    logic [15:0] m_cnt = '0;
    int          m_mode = 0;

    // scoreboard: every handshaken segment must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && seg_valid && seg_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_seg: got bits=%h len=%0d, required no segment", seg_bits, seg_length);
            end else begin
                mon_e = exp_q.pop_front();
                if (seg_bits !== mon_e.bits || seg_length !== mon_e.len) begin
                    tests_failed++;
                    $display("FAIL seg_content: got bits=%h len=%0d, required bits=%h len=%0d",
                             seg_bits, seg_length, mon_e.bits, mon_e.len);
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_one();
        seg_t s;
        s.bits = 16'h8000;
        s.len  = 5'd1;
        exp_q.push_back(s);
    endfunction

    function automatic void model_px(input logic match, input logic eol, input logic req);
        int   c1;
        bit   full;
        int   jj;
        seg_t s;
        if (m_mode == 0 && !req) return;
        jj = jt[m_idx];
        if (match) begin
            c1   = int'(m_cnt) + 1;
            full = (c1 == (1 << jj));
            if (full) begin
                push_one();
                m_cnt = '0;
                if (m_idx < 31) m_idx++;
            end else begin
                m_cnt = 16'(c1);
            end
            if (eol) begin
                if (!full) begin
                    push_one();
                    m_cnt = '0;
                end
                m_mode = 0;
            end else begin
                m_mode = 1;
            end
        end else begin
            s.bits = '0;
            for (int k = 0; k < jj; k++) s.bits[14-k] = m_cnt[jj-1-k];
            s.len = 5'(jj + 1);
            exp_q.push_back(s);
            m_mode = 2;
        end
    endfunction

    task automatic send_px(input logic match, input logic eol, input logic req);
        int waited = 0;
        px_valid = 1'b1;
        px_match = match;
        px_eol = eol;
        run_mode_req = req;
        @(negedge clk);
        while (!px_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!px_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL px_accept_timeout: px_ready=%b after %0d cycles, required 1", px_ready, waited);
        end else begin
            model_px(match, eol, req);
        end
        @(posedge clk); #1;
        px_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d segments outstanding, required 0", name, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic expect_ri(input string name, input logic [3:0] exp_jc);
        int n = 0;
        @(negedge clk);
        while (!ri_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (ri_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_ri_start: got %b, required 1 within 50 cycles", name, ri_start);
        end else begin
            tests_run++;
            if (J_Comp !== exp_jc) begin
                tests_failed++;
                $display("FAIL %s_jcomp: got %0d, required %0d", name, J_Comp, exp_jc);
            end
            @(negedge clk);
            tests_run++;
            if (ri_start !== 1'b0 || J_Comp !== exp_jc || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s_ri_hold: ri_start=%b J_Comp=%0d busy=%b, required 0 %0d 1",
                         name, ri_start, J_Comp, busy, exp_jc);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_ri_done();
        ri_done = 1'b1;
        @(negedge clk);
        if (m_mode == 2) begin
            if (m_idx > 0) m_idx--;
            m_cnt = '0;
            m_mode = 0;
        end
        @(posedge clk); #1;
        ri_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_idx = 0;
        m_cnt = '0;
        m_mode = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (px_ready !== 1'b1 || seg_valid !== 1'b0 || seg_bits !== 16'h0 || seg_length !== 5'd0 ||
            ri_start !== 1'b0 || J_Comp !== 4'd0 || run_index !== 5'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: px_ready=%b seg_valid=%b bits=%h len=%0d ri_start=%b J=%0d idx=%0d busy=%b, required 1 0 0000 0 0 0 0 0",
                     px_ready, seg_valid, seg_bits, seg_length, ri_start, J_Comp, run_index, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_match();
        send_px(1'b1, 1'b0, 1'b1);
        drain("single_match");
        @(negedge clk);
        tests_run++;
        if (run_index !== 5'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_match_idx: run_index=%0d busy=%b, required 1 1", run_index, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ri_j1();
        for (int i = 0; i < 3; i++) send_px(1'b1, 1'b0, 1'b1);
        drain("ri_j1_prep");
        @(negedge clk);
        tests_run++;
        if (run_index !== 5'd4) begin
            tests_failed++;
            $display("FAIL ri_j1_prep_idx: run_index=%0d, required 4", run_index);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send_px(1'b1, 1'b0, 1'b1);
        send_px(1'b0, 1'b0, 1'b1);
        expect_ri("ri_j1", 4'd1);
        pulse_ri_done();
        @(negedge clk);
        tests_run++;
        if (run_index !== 5'd4 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ri_j1_after_done: run_index=%0d busy=%b, required 4 0", run_index, busy);
        end
        @(posedge clk); #1;
        drain("ri_j1");
    endtask

    task automatic test_eol();
        for (int i = 0; i < 8; i++) send_px(1'b1, 1'b0, 1'b1);
        drain("eol_prep");
        @(negedge clk);
        tests_run++;
        if (run_index !== 5'd8) begin
            tests_failed++;
            $display("FAIL eol_prep_idx: run_index=%0d, required 8", run_index);
        end
        @(posedge clk); #1;
        send_px(1'b1, 1'b0, 1'b1);
        send_px(1'b1, 1'b1, 1'b1);
        drain("eol");
        @(negedge clk);
        tests_run++;
        if (run_index !== 5'd8 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL eol_state: run_index=%0d busy=%b, required 8 0", run_index, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored();
        send_px(1'b1, 1'b0, 1'b0);
        send_px(1'b0, 1'b1, 1'b0);
        pulse_ri_done();
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || run_index !== 5'd8) begin
            tests_failed++;
            $display("FAIL ignored_px: busy=%b run_index=%0d, required 0 8", busy, run_index);
        end
        @(posedge clk); #1;
        drain("ignored");
    endtask

    task automatic test_stall();
        logic [15:0] held;
        seg_ready = 1'b0;
        send_px(1'b1, 1'b1, 1'b1);
        px_valid = 1'b1;
        px_match = 1'b1;
        px_eol = 1'b1;
        run_mode_req = 1'b1;
        held = 16'h8000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (px_ready !== 1'b0 || seg_valid !== 1'b1 || seg_bits !== held || seg_length !== 5'd1) begin
                tests_failed++;
                $display("FAIL stall_cycle%0d: px_ready=%b seg_valid=%b bits=%h len=%0d, required 0 1 %h 1",
                         c, px_ready, seg_valid, seg_bits, seg_length, held);
            end
        end
        @(posedge clk); #1;
        seg_ready = 1'b1;
        send_px(1'b1, 1'b1, 1'b1);
        drain("stall");
    endtask

    task automatic test_reset_ri_busy();
        send_px(1'b0, 1'b0, 1'b1);
        expect_ri("rst_busy", 4'd2);
        do_reset();
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || seg_valid !== 1'b0 || seg_bits !== 16'h0 || seg_length !== 5'd0 ||
            ri_start !== 1'b0 || J_Comp !== 4'd0 || run_index !== 5'd0) begin
            tests_failed++;
            $display("FAIL rst_busy_state: busy=%b seg_valid=%b bits=%h len=%0d ri_start=%b J=%0d idx=%0d, required all 0",
                     busy, seg_valid, seg_bits, seg_length, ri_start, J_Comp, run_index);
        end
        @(posedge clk); #1;
        pulse_ri_done();
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || run_index !== 5'd0) begin
            tests_failed++;
            $display("FAIL rst_busy_late_done: busy=%b run_index=%0d, required 0 0", busy, run_index);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_pending();
        seg_ready = 1'b0;
        send_px(1'b1, 1'b0, 1'b1);
        do_reset();
        seg_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (seg_valid !== 1'b0 || run_index !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_pending: seg_valid=%b run_index=%0d, required 0 0", seg_valid, run_index);
        end
        @(posedge clk); #1;
        drain("reset_pending");
    endtask

    task automatic test_saturation();
        int guard = 0;
        while (m_idx < 31 && guard < 40000) begin
            send_px(1'b1, 1'b0, 1'b1);
            guard++;
        end
        drain("sat_prep");
        @(negedge clk);
        tests_run++;
        if (run_index !== 5'd31) begin
            tests_failed++;
            $display("FAIL sat_prep_idx: run_index=%0d, required 31", run_index);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 32768; i++) send_px(1'b1, 1'b0, 1'b1);
        drain("sat");
        @(negedge clk);
        tests_run++;
        if (run_index !== 5'd31 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_idx: run_index=%0d busy=%b, required 31 1", run_index, busy);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_single_match();
        test_ri_j1();
        test_eol();
        test_ignored();
        test_stall();
        test_reset_ri_busy();
        test_reset_pending();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
